// File: rtl/deserializer_pkg.sv
// Shared types and helpers for the stream deserializer.
package deserializer_pkg;

    localparam int DROP_CNT_W = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic int mod_width(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/deser_out_slot.sv
// One-word valid/ready holding slot; drops new words while full and stalled.
module deser_out_slot
    import deserializer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int MOD_W  = 5
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  mod_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [MOD_W-1:0]  mod_o,
    output logic              val_o,
    output logic              overflow_o
);

    slot_state_t state_q, state_d;
    logic        take;
    logic        drop;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q    <= SLOT_EMPTY;
            data_o     <= '0;
            mod_o      <= '0;
            overflow_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_o <= drop;
            if (take) begin
                data_o <= data_i;
                mod_o  <= mod_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            SLOT_EMPTY: begin
                if (load_i) begin
                    take    = 1'b1;
                    state_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (ready_i) begin
                    // Consumer frees the slot this cycle, so a new word can refill it.
                    if (load_i) take = 1'b1;
                    else state_d = SLOT_EMPTY;
                end else if (load_i) begin
                    drop = 1'b1;
                end
            end
        endcase
    end

    assign val_o = (state_q == SLOT_FULL);

endmodule

// File: rtl/deserializer_stream.sv
// Collects LANES-bit beats into DATA_W-bit words with packet-end flush.
// Optional dropped-word counter: define DESER_DROP_CNT_EN.
module deserializer_stream
    import deserializer_pkg::*;
#(
    parameter int  DATA_W    = 16,
    parameter int  LANES     = 1,
    parameter int  MSB_FIRST = 1,
    localparam int MOD_W     = mod_width(DATA_W)
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic [LANES-1:0]      data_i,
    input  logic                  data_val_i,
    input  logic                  data_last_i,
    output logic [DATA_W-1:0]     deser_data_o,
    output logic [MOD_W-1:0]      deser_data_mod_o,
    output logic                  deser_data_val_o,
    input  logic                  deser_data_ready_i,
`ifdef DESER_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0] drop_cnt_o,
`endif
    output logic                  overflow_o
);

    localparam logic [MOD_W-1:0] STEP     = MOD_W'(LANES);
    localparam logic [MOD_W-1:0] LAST_POS = MOD_W'(DATA_W - LANES);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] beat;
    logic [DATA_W-1:0] word;
    logic [MOD_W-1:0]  cnt_q;
    logic [MOD_W-1:0]  cnt_inc;
    logic [MOD_W-1:0]  pos;
    logic              done;

    always_comb begin
        pos     = (MSB_FIRST != 0) ? (LAST_POS - cnt_q) : cnt_q;
        beat    = DATA_W'(data_i) << pos;
        word    = acc_q | beat;
        cnt_inc = cnt_q + STEP;
        done    = data_val_i && (data_last_i || cnt_q == LAST_POS);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (data_val_i) begin
            if (done) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= word;
                cnt_q <= cnt_inc;
            end
        end
    end

    deser_out_slot #(
        .DATA_W (DATA_W),
        .MOD_W  (MOD_W)
    ) u_slot (
        .clk_i      (clk_i),
        .srst_i     (srst_i),
        .load_i     (done),
        .data_i     (word),
        .mod_i      (cnt_inc),
        .ready_i    (deser_data_ready_i),
        .data_o     (deser_data_o),
        .mod_o      (deser_data_mod_o),
        .val_o      (deser_data_val_o),
        .overflow_o (overflow_o)
    );

`ifdef DESER_DROP_CNT_EN
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            drop_cnt_o <= '0;
        end else if (overflow_o && drop_cnt_o != '1) begin
            drop_cnt_o <= drop_cnt_o + DROP_CNT_W'(1);
        end
    end
`endif

endmodule
